// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the RV32M multiply/divide unit.
//   - funct3 op codes MD_MUL..MD_REMU (inst[14:12])
//   - FSM state encoding md_state_e
//   - helpers telling which operands an op treats as signed
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2
  } md_state_e;

  // MUL is excluded: its low word does not depend on operand signs.
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M execute unit (shift-add multiply, restoring divide).
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   op request, sampled only in IDLE
//   i_kill    abort the in-flight op (branch flush)
//   i_funct3  op select, inst[14:12]
//   i_rs1     operand A (multiplicand / dividend)
//   i_rs2     operand B (multiplier / divisor)
//   o_busy    high while an op is in flight
//   o_done    one-cycle pulse, o_result valid
//   o_result  op result, held until the next completed op
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  md_state_e         r_state;
  logic [2:0]        r_op;
  logic              r_sa;
  logic              r_sb;
  logic              r_special;
  logic [XLEN-1:0]   r_spec_val;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_a;       // multiplicand magnitude
  logic [XLEN-1:0]   r_b;       // divisor magnitude
  logic [2*XLEN-1:0] r_prod;    // {partial product, remaining multiplier bits}
  logic [XLEN-1:0]   r_rem;     // partial remainder (always < divisor)
  logic [XLEN-1:0]   r_quo;     // dividend bits shift out as quotient bits shift in
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_val;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_diff;
  logic [XLEN-1:0] w_mulh_neg;
  logic [XLEN-1:0] w_fin;

  assign w_sa    = op_signed_a(i_funct3) & i_rs1[XLEN-1];
  assign w_sb    = op_signed_b(i_funct3) & i_rs2[XLEN-1];
  // Most-negative operand negates to itself, which is its exact unsigned magnitude.
  assign w_abs_a = w_sa ? -i_rs1 : i_rs1;
  assign w_abs_b = w_sb ? -i_rs2 : i_rs2;

  assign w_div0 = i_funct3[2] && (i_rs2 == '0);
  assign w_ovf  = ((i_funct3 == MD_DIV) || (i_funct3 == MD_REM)) &&
                  (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    if (w_div0) w_spec_val = i_funct3[1] ? i_rs1 : '1;
    else        w_spec_val = i_funct3[1] ? '0 : i_rs1;
  end

  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  // High word of the negated product: ~hi plus the carry out of negating the low word.
  assign w_mulh_neg = ~r_prod[2*XLEN-1:XLEN] + XLEN'(r_prod[XLEN-1:0] == '0);

  always_comb begin
    w_fin = '0;
    if (r_special) begin
      w_fin = r_spec_val;
    end else begin
      unique case (r_op)
        MD_MUL:                      w_fin = r_prod[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: w_fin = (r_sa ^ r_sb) ? w_mulh_neg
                                                            : r_prod[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:             w_fin = (r_sa ^ r_sb) ? -r_quo : r_quo;
        default:                     w_fin = r_sa ? -r_rem : r_rem;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= MD_IDLE;
      r_op       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        MD_IDLE: begin
          if (i_start && !i_kill) begin
            r_op       <= i_funct3;
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_a        <= w_abs_a;
            r_b        <= w_abs_b;
            r_prod     <= {{XLEN{1'b0}}, w_abs_b};
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_cnt      <= CNT_W'(XLEN);
            r_busy     <= 1'b1;
            r_special  <= w_div0 || w_ovf;
            r_spec_val <= w_spec_val;
            r_state    <= (w_div0 || w_ovf) ? MD_FINISH : MD_CALC;
          end
        end
        MD_CALC: begin
          if (i_kill) begin
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_op[2]) begin
              r_rem <= w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], ~w_div_diff[XLEN]};
            end else begin
              r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= MD_FINISH;
          end
        end
        MD_FINISH: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
          if (!i_kill) begin
            r_done   <= 1'b1;
            r_result <= w_fin;
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule
